s_axis_rq_arb: RTL and testbench
================================

S_AXIS_RQ_ARB -- requirements
Module: s_axis_rq_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, the stream data width in bits.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, the byte-enable width.
REQ-003 SHALL have port user_clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port user_reset, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port s0_axis_rq_tdata, input, DATA_WIDTH bits: requester 0 TLP data (header in the first beat).
REQ-006 SHALL have port s0_axis_rq_tkeep, input, KEEP_WIDTH bits: requester 0 byte enables.
REQ-007 SHALL have ports s0_axis_rq_tlast (input), s0_axis_rq_tvalid (input) and s0_axis_rq_tready (output), 1 bit each: requester 0 end-of-packet and handshake.
REQ-008 SHALL have port s0_axis_rq_tuser, input, 4 bits: requester 0 sideband.
REQ-009 SHALL have ports s1_axis_rq_tdata, s1_axis_rq_tkeep, s1_axis_rq_tlast, s1_axis_rq_tvalid, s1_axis_rq_tready and s1_axis_rq_tuser: requester 1, with the same widths and directions as requester 0.
REQ-010 SHALL have ports s_axis_rq_tdata, s_axis_rq_tkeep, s_axis_rq_tlast, s_axis_rq_tuser[3:0] and s_axis_rq_tvalid, all outputs: the merged stream to the RQ adapter.
REQ-011 SHALL have port s_axis_rq_tready, input, 1 bit: the downstream ready.
REQ-012 SHALL have port arb_grant, output, 2 bits, one-hot: the requester that currently owns the output (00 when idle).

Function
REQ-013 SHALL merge the two requester streams onto one output, switching requester only at packet boundaries; beats of different packets SHALL never interleave.
REQ-014 SHALL implement a state machine with states IDLE, LOCK0 and LOCK1.
REQ-015 Output register: SHALL hold out_valid plus the data, keep, last and user fields; the stage accepts a beat when stage_en = !out_valid || s_axis_rq_tready.
REQ-016 Latency SHALL be exactly 1 cycle from input acceptance to s_axis_rq_tvalid; throughput SHALL be 1 beat per cycle while the downstream ready is held high.
REQ-017 In IDLE with stage_en high and at least one tvalid high, a winner SHALL be chosen combinationally and its first beat accepted in that same cycle.
REQ-018 Transition rules SHALL be:
- IDLE goes to LOCKn if the accepted first beat has tlast=0.
- IDLE stays IDLE if the first beat has tlast=1 (single-beat TLP).
- LOCKn returns to IDLE on acceptance of a beat from port n with tlast=1.
REQ-019 In LOCKn, sn_axis_rq_tready SHALL equal stage_en and the other port's tready SHALL be 0; in IDLE only the winner's tready SHALL be asserted.
REQ-020 Round-robin: a 1-bit last_grant SHALL update when a first beat is accepted; when both ports are valid in IDLE, the port not equal to last_grant SHALL win; a lone valid port SHALL win regardless of last_grant.
REQ-021 A first beat offered while the output is stalled (stage_en=0) SHALL NOT be accepted and SHALL NOT change last_grant.
REQ-022 tvalid deasserting mid-packet SHALL hold the lock; the other port SHALL stay blocked until the locked packet's tlast is accepted.
REQ-023 Output fields SHALL be stable while s_axis_rq_tvalid=1 and s_axis_rq_tready=0.
REQ-024 arb_grant SHALL be 01 in LOCK0 and 10 in LOCK1; in IDLE it SHALL show the combinational winner, or 00 if no port is valid.

Reset
REQ-025 While user_reset=1, the block SHALL be in state IDLE, with out_valid=0, last_grant=1 (so port 0 wins first), both tready outputs at 0, and s_axis_rq_tvalid, s_axis_rq_tlast and arb_grant at 0.
REQ-026 Reset asserted mid-packet SHALL discard the partial packet and any registered beat; after release, arbitration SHALL restart from IDLE.

Configuration
REQ-027 With macro S_AXIS_RQ_ARB_FIXED_PRIO_EN defined, port 0 SHALL always win in IDLE when valid, and last_grant SHALL be unused.
REQ-028 Without the macro, round-robin arbitration per REQ-020 SHALL apply; packet locking SHALL be identical in both builds.

Verification
REQ-029 Scenario: after reset, both ports present 3-beat packets with downstream ready=1 -> output carries port 0's 3 beats and then port 1's 3 beats, with no gap and first output valid 1 cycle after the first acceptance.
REQ-030 Scenario: both ports continuously offer 1-beat packets -> output grants alternate 0,1,0,1 (round-robin build); with S_AXIS_RQ_ARB_FIXED_PRIO_EN defined, the output is all port 0.
REQ-031 Scenario: port 0 sends a 4-beat packet, deasserts tvalid after beat 2 for 5 cycles while port 1 is valid -> port 1 tready stays 0, and port 0's beats 3 and 4 follow before any port 1 beat.
REQ-032 Scenario: downstream ready is held at 0 for 4 cycles mid-packet -> output data is held stable, at most 1 beat is buffered, and no beat is lost or duplicated.
REQ-033 Scenario: user_reset is pulsed during beat 2 of a 4-beat packet -> s_axis_rq_tvalid drops to 0 immediately, and the next packet is arbitrated fresh with port 0 winning a tie.

Source files
------------

// File: rtl/s_axis_rq_arb.sv
// Two-requester RQ stream arbiter; packet-locked, round-robin (port 0 fixed priority with S_AXIS_RQ_ARB_FIXED_PRIO_EN).
// Latency: 1 cycle from input acceptance to s_axis_rq_tvalid, 1 beat/cycle sustained.
// Backpressure: a single output register; input tready is withheld whenever that register is full and stalled.
module s_axis_rq_arb #(
    parameter int DATA_WIDTH = 128,
    parameter int KEEP_WIDTH = DATA_WIDTH/8
) (
    input  logic                  user_clk,
    input  logic                  user_reset,
    input  logic [DATA_WIDTH-1:0] s0_axis_rq_tdata,
    input  logic [KEEP_WIDTH-1:0] s0_axis_rq_tkeep,
    input  logic                  s0_axis_rq_tlast,
    input  logic                  s0_axis_rq_tvalid,
    output logic                  s0_axis_rq_tready,
    input  logic [3:0]            s0_axis_rq_tuser,
    input  logic [DATA_WIDTH-1:0] s1_axis_rq_tdata,
    input  logic [KEEP_WIDTH-1:0] s1_axis_rq_tkeep,
    input  logic                  s1_axis_rq_tlast,
    input  logic                  s1_axis_rq_tvalid,
    output logic                  s1_axis_rq_tready,
    input  logic [3:0]            s1_axis_rq_tuser,
    output logic [DATA_WIDTH-1:0] s_axis_rq_tdata,
    output logic [KEEP_WIDTH-1:0] s_axis_rq_tkeep,
    output logic                  s_axis_rq_tlast,
    output logic [3:0]            s_axis_rq_tuser,
    output logic                  s_axis_rq_tvalid,
    input  logic                  s_axis_rq_tready,
    output logic [1:0]            arb_grant
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] dat;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
        logic [3:0]            user;
    } beat_t;

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t state, state_nxt;
    logic   out_valid;
    beat_t  out_beat, in_beat;
    logic   stage_en, win_vld, win_sel, acc0, acc1;

    assign stage_en = !out_valid || s_axis_rq_tready;
    assign win_vld  = s0_axis_rq_tvalid || s1_axis_rq_tvalid;

`ifdef S_AXIS_RQ_ARB_FIXED_PRIO_EN
    assign win_sel = !s0_axis_rq_tvalid;
`else
    logic last_grant;

    // On a tie the port that did not win last time goes next
    assign win_sel = (s0_axis_rq_tvalid && s1_axis_rq_tvalid) ? !last_grant : !s0_axis_rq_tvalid;
`endif

    // Readies and grant are forced low while reset is held, independent of state
    always_comb begin
        s0_axis_rq_tready = 1'b0;
        s1_axis_rq_tready = 1'b0;
        arb_grant         = 2'b00;
        if (!user_reset) begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        arb_grant         = win_sel ? 2'b10 : 2'b01;
                        s0_axis_rq_tready = stage_en && !win_sel;
                        s1_axis_rq_tready = stage_en && win_sel;
                    end
                end
                LOCK0: begin
                    arb_grant         = 2'b01;
                    s0_axis_rq_tready = stage_en;
                end
                LOCK1: begin
                    arb_grant         = 2'b10;
                    s1_axis_rq_tready = stage_en;
                end
                default: ;
            endcase
        end
    end

    assign acc0 = s0_axis_rq_tvalid && s0_axis_rq_tready;
    assign acc1 = s1_axis_rq_tvalid && s1_axis_rq_tready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (acc0 && !s0_axis_rq_tlast)
                    state_nxt = LOCK0;
                else if (acc1 && !s1_axis_rq_tlast)
                    state_nxt = LOCK1;
            end
            LOCK0: if (acc0 && s0_axis_rq_tlast) state_nxt = IDLE;
            LOCK1: if (acc1 && s1_axis_rq_tlast) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_beat = acc1 ? beat_t'{s1_axis_rq_tdata, s1_axis_rq_tkeep, s1_axis_rq_tlast, s1_axis_rq_tuser}
                       : beat_t'{s0_axis_rq_tdata, s0_axis_rq_tkeep, s0_axis_rq_tlast, s0_axis_rq_tuser};
    end

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_beat  <= '0;
        end else begin
            state <= state_nxt;
            if (stage_en) begin
                out_valid <= acc0 || acc1;
                if (acc0 || acc1)
                    out_beat <= in_beat;
            end
        end
    end

`ifndef S_AXIS_RQ_ARB_FIXED_PRIO_EN
    // Reset to 1 so port 0 wins the first tie
    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset)
            last_grant <= 1'b1;
        else if (state == IDLE && (acc0 || acc1))
            last_grant <= acc1;
    end
`endif

    assign s_axis_rq_tvalid = out_valid;
    assign s_axis_rq_tdata  = out_beat.dat;
    assign s_axis_rq_tkeep  = out_beat.keep;
    assign s_axis_rq_tlast  = out_beat.last;
    assign s_axis_rq_tuser  = out_beat.user;

endmodule

// File: tb/tb_s_axis_rq_arb.sv
// Scoreboard bench for s_axis_rq_arb: directed packets on both requesters, expected output order hand-computed.
module tb_s_axis_rq_arb;

    localparam int DW = 128;
    localparam int KW = 16;

    logic          user_clk = 1'b0;
    logic          user_reset;
    logic [DW-1:0] s0_axis_rq_tdata, s1_axis_rq_tdata, s_axis_rq_tdata;
    logic [KW-1:0] s0_axis_rq_tkeep, s1_axis_rq_tkeep, s_axis_rq_tkeep;
    logic          s0_axis_rq_tlast, s1_axis_rq_tlast, s_axis_rq_tlast;
    logic          s0_axis_rq_tvalid, s1_axis_rq_tvalid, s_axis_rq_tvalid;
    logic          s0_axis_rq_tready, s1_axis_rq_tready, s_axis_rq_tready;
    logic [3:0]    s0_axis_rq_tuser, s1_axis_rq_tuser, s_axis_rq_tuser;
    logic [1:0]    arb_grant;

    s_axis_rq_arb #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
        .user_clk         (user_clk),
        .user_reset       (user_reset),
        .s0_axis_rq_tdata (s0_axis_rq_tdata),
        .s0_axis_rq_tkeep (s0_axis_rq_tkeep),
        .s0_axis_rq_tlast (s0_axis_rq_tlast),
        .s0_axis_rq_tvalid(s0_axis_rq_tvalid),
        .s0_axis_rq_tready(s0_axis_rq_tready),
        .s0_axis_rq_tuser (s0_axis_rq_tuser),
        .s1_axis_rq_tdata (s1_axis_rq_tdata),
        .s1_axis_rq_tkeep (s1_axis_rq_tkeep),
        .s1_axis_rq_tlast (s1_axis_rq_tlast),
        .s1_axis_rq_tvalid(s1_axis_rq_tvalid),
        .s1_axis_rq_tready(s1_axis_rq_tready),
        .s1_axis_rq_tuser (s1_axis_rq_tuser),
        .s_axis_rq_tdata  (s_axis_rq_tdata),
        .s_axis_rq_tkeep  (s_axis_rq_tkeep),
        .s_axis_rq_tlast  (s_axis_rq_tlast),
        .s_axis_rq_tuser  (s_axis_rq_tuser),
        .s_axis_rq_tvalid (s_axis_rq_tvalid),
        .s_axis_rq_tready (s_axis_rq_tready),
        .arb_grant        (arb_grant)
    );

    always #5 user_clk = ~user_clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic [3:0]    u;
    } beat_t;

    beat_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    function automatic beat_t mk(input int p, input int pkt, input int b, input int n);
        beat_t x;
        x.d = {32'(p), 32'(pkt), 32'(b), 32'hC0DE_0000 ^ 32'(p * 256 + pkt)};
        x.k = (b == n - 1) ? 16'h0FFF : 16'hFFFF;
        x.l = (b == n - 1);
        x.u = {1'(p), 3'(b)};
        return x;
    endfunction

    task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic setp(input int p, input beat_t x, input logic v);
        if (p == 0) begin
            s0_axis_rq_tdata = x.d; s0_axis_rq_tkeep = x.k; s0_axis_rq_tlast = x.l;
            s0_axis_rq_tuser = x.u; s0_axis_rq_tvalid = v;
        end else begin
            s1_axis_rq_tdata = x.d; s1_axis_rq_tkeep = x.k; s1_axis_rq_tlast = x.l;
            s1_axis_rq_tuser = x.u; s1_axis_rq_tvalid = v;
        end
    endtask

    function automatic logic rdy(input int p);
        return (p == 0) ? s0_axis_rq_tready : s1_axis_rq_tready;
    endfunction

    // Present one beat and hold it until a handshake is seen (bounded)
    task automatic offer(input int p, input beat_t x);
        logic acc = 1'b0;
        int   n   = 0;
        setp(p, x, 1'b1);
        while (!acc && n < 200) begin
            @(negedge user_clk);
            acc = rdy(p);
            @(posedge user_clk);
            #1;
            n++;
        end
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL handshake_timeout: port %0d got no tready, expected one within 200 cycles", p);
        end
    endtask

    task automatic send(input int p, input int pkt, input int n, input int gap_at, input int gap_len);
        for (int b = 0; b < n; b++) begin
            if (b == gap_at) begin
                setp(p, '0, 1'b0);
                repeat (gap_len) @(posedge user_clk);
                #1;
            end
            offer(p, mk(p, pkt, b, n));
        end
        setp(p, '0, 1'b0);
    endtask

    task automatic push_pkt(input int p, input int pkt, input int n);
        for (int b = 0; b < n; b++)
            exp_q.push_back(mk(p, pkt, b, n));
    endtask

    task automatic drain;
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge user_clk);
            n++;
        end
        check("drain_remaining", 160'(exp_q.size()), 160'(0));
        exp_q.delete();
        repeat (2) @(posedge user_clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every output handshake; while stalled the head must be held
    logic stall = 1'b0;
    always @(negedge user_clk) begin
        beat_t cur;
        cur = {s_axis_rq_tdata, s_axis_rq_tkeep, s_axis_rq_tlast, s_axis_rq_tuser};
        if (user_reset) begin
            stall = 1'b0;
        end else begin
            if (stall && exp_q.size() != 0)
                check("stall_hold", 160'(cur), 160'(exp_q[0]));
            if (s_axis_rq_tvalid && s_axis_rq_tready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_beat: got %h expected no output", cur);
                end else begin
                    check("out_beat", 160'(cur), 160'(exp_q.pop_front()));
                end
            end
            stall = s_axis_rq_tvalid && !s_axis_rq_tready;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        user_reset       = 1'b1;
        s_axis_rq_tready = 1'b1;
        setp(0, mk(0, 99, 0, 1), 1'b1);
        setp(1, mk(1, 99, 0, 1), 1'b1);

        // Reset state, with both requesters pushing
        repeat (2) @(negedge user_clk);
        check("rst_tvalid", 160'(s_axis_rq_tvalid), 160'(0));
        check("rst_tlast", 160'(s_axis_rq_tlast), 160'(0));
        check("rst_grant", 160'(arb_grant), 160'(2'b00));
        check("rst_s0_tready", 160'(s0_axis_rq_tready), 160'(0));
        check("rst_s1_tready", 160'(s1_axis_rq_tready), 160'(0));
        setp(0, '0, 1'b0);
        setp(1, '0, 1'b0);
        @(posedge user_clk);
        #1 user_reset = 1'b0;

        // Two 3-beat packets, port 0 first, back to back with 1-cycle latency
        push_pkt(0, 1, 3);
        push_pkt(1, 1, 3);
        fork
            send(0, 1, 3, -1, 0);
            send(1, 1, 3, -1, 0);
            begin
                @(negedge user_clk);
                check("first_tvalid_c0", 160'(s_axis_rq_tvalid), 160'(0));
                check("first_grant", 160'(arb_grant), 160'(2'b01));
                for (int k = 1; k <= 6; k++) begin
                    @(negedge user_clk);
                    check("no_gap_tvalid", 160'(s_axis_rq_tvalid), 160'(1));
                end
            end
        join
        drain();

        // Continuous single-beat packets on both ports
`ifdef S_AXIS_RQ_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) push_pkt(0, 10 + i, 1);
        for (int i = 0; i < 4; i++) push_pkt(1, 10 + i, 1);
`else
        for (int i = 0; i < 4; i++) begin
            push_pkt(0, 10 + i, 1);
            push_pkt(1, 10 + i, 1);
        end
`endif
        fork
            for (int i = 0; i < 4; i++) send(0, 10 + i, 1, -1, 0);
            for (int i = 0; i < 4; i++) send(1, 10 + i, 1, -1, 0);
        join
        drain();

        // Port 0 pauses mid-packet; port 1 must stay blocked
        push_pkt(0, 20, 4);
        push_pkt(1, 20, 2);
        fork
            send(0, 20, 4, 2, 5);
            send(1, 20, 2, -1, 0);
            for (int k = 0; k < 9; k++) begin
                @(negedge user_clk);
                check("lock_s1_tready", 160'(s1_axis_rq_tready), 160'(0));
            end
        join
        drain();

        // Downstream stall of 4 cycles mid-packet
        push_pkt(1, 30, 4);
        fork
            send(1, 30, 4, -1, 0);
            begin
                repeat (2) @(posedge user_clk);
                #1 s_axis_rq_tready = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge user_clk);
                    check("stall_s1_tready", 160'(s1_axis_rq_tready), 160'(0));
                    check("stall_tvalid", 160'(s_axis_rq_tvalid), 160'(1));
                end
                @(posedge user_clk);
                #1 s_axis_rq_tready = 1'b1;
            end
        join
        drain();

        // Reset pulsed while beat 2 of a 4-beat packet sits in the output register
        exp_q.push_back(mk(0, 40, 0, 4));
        offer(0, mk(0, 40, 0, 4));
        offer(0, mk(0, 40, 1, 4));
        user_reset = 1'b1;
        setp(0, mk(0, 40, 2, 4), 1'b1);
        #1;
        check("midrst_tvalid", 160'(s_axis_rq_tvalid), 160'(0));
        check("midrst_tlast", 160'(s_axis_rq_tlast), 160'(0));
        check("midrst_grant", 160'(arb_grant), 160'(2'b00));
        check("midrst_s0_tready", 160'(s0_axis_rq_tready), 160'(0));
        repeat (2) @(posedge user_clk);
        #1;
        setp(0, '0, 1'b0);
        user_reset = 1'b0;
        check("postrst_tvalid", 160'(s_axis_rq_tvalid), 160'(0));
        push_pkt(0, 41, 1);
        push_pkt(1, 41, 1);
        fork
            send(0, 41, 1, -1, 0);
            send(1, 41, 1, -1, 0);
            begin
                @(negedge user_clk);
                check("postrst_grant", 160'(arb_grant), 160'(2'b01));
            end
        join
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
